bcd_time_counter: RTL and testbench
===================================

Name: bcd_time_counter

Overview:
- Parametrised BCD time-of-day core for the binary-clock family: prescaler, seconds, minutes and hours in BCD digits.
- Supports 12h or 24h mode, button fast-set with minute-to-hour carry, and a validated parallel load.
- Sits between the top-level button/clock inputs and the LED/WS2812 display drivers, replacing ad-hoc digit counters.

Parameters:
- MAIN_CLK, 12000000: input clock frequency in Hz; prescaler terminal count is MAIN_CLK-1. Benches use 2.
- SET_RATE, 8: minute advances per second while SET_N is held. Advance period = max(1, MAIN_CLK/SET_RATE) cycles, integer floor.
- MODE_12H, 0: 0 = 24h (00..23), 1 = 12h (01..12 with PM flag).

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous reset, active-high
- SET_N  in  1  set button, active-low, asynchronous to CLK
- LOAD  in  1  single-cycle load strobe
- LOAD_H1  in  2 / LOAD_H0  in  4 / LOAD_M1  in  3 / LOAD_M0  in  4  load value, BCD
- TICK_1HZ  out  1  one-cycle pulse at prescaler terminal count
- H1  out  2 / H0  out  4 / M1  out  3 / M0  out  4 / S1  out  3 / S0  out  4  time, BCD
- PM  out  1  12h mode only; tied 0 in 24h mode
- ROLLOVER  out  1  one-cycle pulse on day wrap
- SETTING  out  1  synchronised set-active level
- LOAD_ERR  out  1  one-cycle pulse when a load is rejected
- ALARM_H1 2 / ALARM_H0 4 / ALARM_M1 3 / ALARM_M0 4  in; ALARM  out  1  (see Optional Feature)

Behaviour:
- Reset values (RST high, takes effect immediately, asynchronous):
  - 24h mode: time 00:00:00.
  - 12h mode: time 12:00:00, PM=0.
  - All pulse outputs 0, SETTING=0, prescaler 0, synchroniser flops 1, set-rate counter 0.
- Reset mid-operation (including mid-set or mid-load) aborts everything; the first count occurs MAIN_CLK cycles after RST falls.
- SET_N passes through a 2-flop synchroniser. SETTING = inverted synchronised value, so latency is 2 cycles.
- Prescaler:
  - Counts 0..MAIN_CLK-1 and wraps.
  - TICK_1HZ is high exactly in the cycle where count == MAIN_CLK-1.
  - Free-running except as noted under LOAD.
- Per-cycle priority, highest first: LOAD, then SETTING, then TICK_1HZ.
- LOAD:
  - Accepted only if LOAD_M0<=9, LOAD_M1<=5, LOAD_H0<=9, and the hour is valid for the mode: 00..23 in 24h; 01..12 in 12h.
  - On accept: H/M take the load value next cycle, S becomes 00, prescaler resets to 0, PM is unchanged.
  - On reject: time unchanged and LOAD_ERR pulses next cycle.
- Set mode (SETTING=1):
  - S held at 00; tick increments suppressed.
  - Minutes advance by 1 every advance period. The first advance occurs one full period after SETTING rises.
  - Minute carry propagates into hours with normal wrap rules, including ROLLOVER and the PM toggle.
  - On release, counting resumes on the next TICK_1HZ.
- Normal counting, on each TICK_1HZ:
  - S0 9->0 carries to S1; S1 5->0 carries to M0; M0 9->0 carries to M1; M1 5->0 carries to hours.
- Hour wrap, 24h mode: 23 -> 00 with ROLLOVER pulse, coincident with the digits updating.
- Hour wrap, 12h mode:
  - 11 -> 12 toggles PM; ROLLOVER pulses when PM goes 1->0.
  - 12 -> 01, no toggle.
  - 09 -> 10 sets H1=1, H0=0.
- All digit outputs are registered. Update latency is 1 cycle after the tick or advance event.
- Digits are never outside their BCD range. Any illegal internal state, which is unreachable, recovers to the reset value on the next increment.

Optional Feature:
- Macro: BCD_TIME_ALARM_EN.
- With the macro defined:
  - ALARM rises when H:M equals ALARM_H1..ALARM_M0 and S transitions to 00 on a tick (not during SETTING).
  - ALARM stays high for 60 ticks, or until SETTING rises, whichever comes first.
  - Reset clears ALARM.
- Without the macro: ALARM is tied 0, the alarm inputs are ignored, and no alarm logic is synthesised.

Test Plan:
- MAIN_CLK=2: release RST -> TICK_1HZ every 2nd cycle; S0=1 after the first tick; 00:00:59 -> 00:01:00 after 60 ticks.
- LOAD 23:59, run 60 ticks -> 00:00:00 with a single-cycle ROLLOVER on that tick.
- Hold SET_N=0 from 23:58 with SET_RATE=8 (period 1 cycle) -> SETTING high after 2 cycles; minutes increment every cycle through 23:59 -> 00:00, ROLLOVER pulses, S stays 00.
- LOAD 24:00, then 12:60 (M1=6) -> both rejected; LOAD_ERR pulse each time; time unchanged. In 12h mode, LOAD 00:30 -> rejected.
- MODE_12H=1: from reset 12:00 AM; LOAD 11:59, run 60 ticks -> 12:00, PM=1; repeat to 12:59 -> 01:00, PM=1; next 11:59 -> 12:00, PM=0 with ROLLOVER.
- Assert RST mid-set at 05:37 -> immediately 00:00:00. With BCD_TIME_ALARM_EN and alarm 00:02: ALARM rises at 00:02:00, drops after 60 ticks, or earlier when SET_N is pressed.

Source files
------------

// File: rtl/bcd_time_counter.sv
// BCD time-of-day core: prescaler, seconds, minutes and hours as BCD digits.
// 24h or 12h (with PM flag) mode, button fast-set with carry, validated load.
// Optional alarm comparator is compiled in with `define BCD_TIME_ALARM_EN.
module bcd_time_counter #(
  parameter int unsigned MAIN_CLK = 12000000,
  parameter int unsigned SET_RATE = 8,
  parameter int unsigned MODE_12H = 0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SET_N,
  input  logic       LOAD,
  input  logic [1:0] LOAD_H1,
  input  logic [3:0] LOAD_H0,
  input  logic [2:0] LOAD_M1,
  input  logic [3:0] LOAD_M0,
  input  logic [1:0] ALARM_H1,
  input  logic [3:0] ALARM_H0,
  input  logic [2:0] ALARM_M1,
  input  logic [3:0] ALARM_M0,
  output logic       TICK_1HZ,
  output logic [1:0] H1,
  output logic [3:0] H0,
  output logic [2:0] M1,
  output logic [3:0] M0,
  output logic [2:0] S1,
  output logic [3:0] S0,
  output logic       PM,
  output logic       ROLLOVER,
  output logic       SETTING,
  output logic       LOAD_ERR,
  output logic       ALARM
);

  localparam int unsigned PRE_W   = (MAIN_CLK > 1) ? $clog2(MAIN_CLK) : 1;
  localparam int unsigned ADV_RAW = (SET_RATE == 0) ? MAIN_CLK : MAIN_CLK / SET_RATE;
  localparam int unsigned ADV_PER = (ADV_RAW < 1) ? 1 : ADV_RAW;
  localparam int unsigned ADV_W   = (ADV_PER > 1) ? $clog2(ADV_PER) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(MAIN_CLK - 1);
  localparam logic [ADV_W-1:0] ADV_LAST = ADV_W'(ADV_PER - 1);
  localparam logic [1:0] H1_RST = (MODE_12H != 0) ? 2'd1 : 2'd0;
  localparam logic [3:0] H0_RST = (MODE_12H != 0) ? 4'd2 : 4'd0;

  logic [PRE_W-1:0] pre_q;
  logic [ADV_W-1:0] adv_q;
  logic [1:0]       sync_q;
  logic [1:0]       h1_q, h1_d, h1_inc;
  logic [3:0]       h0_q, h0_d, h0_inc;
  logic [2:0]       m1_q, m1_d, m1_inc;
  logic [3:0]       m0_q, m0_d, m0_inc;
  logic [2:0]       s1_q, s1_d, s1_inc;
  logic [3:0]       s0_q, s0_d, s0_inc;
  logic             pm_q, pm_d, pm_inc;
  logic             roll_q, roll_d, roll_inc;
  logic             lerr_q, lerr_d;
  logic             s_carry, m_carry, load_ok, advance, tick, setting;

  assign tick    = (pre_q == PRE_LAST);
  assign setting = ~sync_q[1];
  assign advance = setting && (adv_q == ADV_LAST);

  assign TICK_1HZ = tick;
  assign SETTING  = setting;
  assign H1 = h1_q;
  assign H0 = h0_q;
  assign M1 = m1_q;
  assign M0 = m0_q;
  assign S1 = s1_q;
  assign S0 = s0_q;
  assign PM = (MODE_12H != 0) ? pm_q : 1'b0;
  assign ROLLOVER = roll_q;
  assign LOAD_ERR = lerr_q;

  // Load value check: BCD ranges plus mode-dependent hour range.
  always_comb begin
    load_ok = (LOAD_M0 <= 4'd9) && (LOAD_M1 <= 3'd5) && (LOAD_H0 <= 4'd9);
    if (MODE_12H != 0) begin
      load_ok = load_ok && (((LOAD_H1 == 2'd0) && (LOAD_H0 != 4'd0)) ||
                            ((LOAD_H1 == 2'd1) && (LOAD_H0 <= 4'd2)));
    end else begin
      load_ok = load_ok && ((LOAD_H1 < 2'd2) || ((LOAD_H1 == 2'd2) && (LOAD_H0 <= 4'd3)));
    end
  end

  // Seconds and minutes increment; illegal digits recover to 00 without carry.
  always_comb begin
    s_carry = 1'b0;
    s1_inc  = s1_q;
    s0_inc  = s0_q + 4'd1;
    if ((s0_q > 4'd9) || (s1_q > 3'd5)) begin
      s1_inc = '0;
      s0_inc = '0;
    end else if (s0_q == 4'd9) begin
      s0_inc = '0;
      if (s1_q == 3'd5) begin
        s1_inc  = '0;
        s_carry = 1'b1;
      end else begin
        s1_inc = s1_q + 3'd1;
      end
    end
    m_carry = 1'b0;
    m1_inc  = m1_q;
    m0_inc  = m0_q + 4'd1;
    if ((m0_q > 4'd9) || (m1_q > 3'd5)) begin
      m1_inc = '0;
      m0_inc = '0;
    end else if (m0_q == 4'd9) begin
      m0_inc = '0;
      if (m1_q == 3'd5) begin
        m1_inc  = '0;
        m_carry = 1'b1;
      end else begin
        m1_inc = m1_q + 3'd1;
      end
    end
  end

  // Hour increment with mode-specific wrap, PM toggle and day rollover.
  always_comb begin
    h1_inc   = h1_q;
    h0_inc   = h0_q + 4'd1;
    pm_inc   = pm_q;
    roll_inc = 1'b0;
    if (MODE_12H != 0) begin
      if ((h1_q > 2'd1) || (h0_q > 4'd9) || ((h1_q == 2'd0) && (h0_q == 4'd0)) ||
          ((h1_q == 2'd1) && (h0_q > 4'd2))) begin
        h1_inc = H1_RST;
        h0_inc = H0_RST;
        pm_inc = 1'b0;
      end else if ((h1_q == 2'd1) && (h0_q == 4'd1)) begin
        h1_inc   = 2'd1;
        h0_inc   = 4'd2;
        pm_inc   = ~pm_q;
        roll_inc = pm_q;  // PM 1->0 marks the start of a new day
      end else if ((h1_q == 2'd1) && (h0_q == 4'd2)) begin
        h1_inc = 2'd0;
        h0_inc = 4'd1;
      end else if (h0_q == 4'd9) begin
        h1_inc = 2'd1;
        h0_inc = 4'd0;
      end
    end else begin
      if ((h1_q > 2'd2) || (h0_q > 4'd9) || ((h1_q == 2'd2) && (h0_q > 4'd3))) begin
        h1_inc = H1_RST;
        h0_inc = H0_RST;
      end else if ((h1_q == 2'd2) && (h0_q == 4'd3)) begin
        h1_inc   = 2'd0;
        h0_inc   = 4'd0;
        roll_inc = 1'b1;
      end else if (h0_q == 4'd9) begin
        h1_inc = h1_q + 2'd1;
        h0_inc = 4'd0;
      end
    end
  end

  // Next time state: LOAD beats set mode, which beats the normal tick.
  always_comb begin
    h1_d = h1_q;
    h0_d = h0_q;
    m1_d = m1_q;
    m0_d = m0_q;
    s1_d = s1_q;
    s0_d = s0_q;
    pm_d = pm_q;
    roll_d = 1'b0;
    lerr_d = 1'b0;
    if (LOAD) begin
      if (load_ok) begin
        h1_d = LOAD_H1;
        h0_d = LOAD_H0;
        m1_d = LOAD_M1;
        m0_d = LOAD_M0;
        s1_d = '0;
        s0_d = '0;
      end else begin
        lerr_d = 1'b1;
      end
    end else if (setting || (tick && s_carry)) begin
      if (setting) begin
        s1_d = '0;
        s0_d = '0;
      end else begin
        s1_d = s1_inc;
        s0_d = s0_inc;
      end
      if (!setting || advance) begin
        m1_d = m1_inc;
        m0_d = m0_inc;
        if (m_carry) begin
          h1_d   = h1_inc;
          h0_d   = h0_inc;
          pm_d   = pm_inc;
          roll_d = roll_inc;
        end
      end
    end else if (tick) begin
      s1_d = s1_inc;
      s0_d = s0_inc;
    end
  end

  // Prescaler, set-rate divider, button synchroniser and time registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pre_q  <= '0;
      adv_q  <= '0;
      sync_q <= 2'b11;
      h1_q   <= H1_RST;
      h0_q   <= H0_RST;
      m1_q   <= '0;
      m0_q   <= '0;
      s1_q   <= '0;
      s0_q   <= '0;
      pm_q   <= 1'b0;
      roll_q <= 1'b0;
      lerr_q <= 1'b0;
    end else begin
      if (LOAD && load_ok) pre_q <= '0;
      else if (tick)       pre_q <= '0;
      else                 pre_q <= pre_q + 1'b1;
      if (!setting || advance) adv_q <= '0;
      else                     adv_q <= adv_q + 1'b1;
      sync_q <= {sync_q[0], SET_N};
      h1_q   <= h1_d;
      h0_q   <= h0_d;
      m1_q   <= m1_d;
      m0_q   <= m0_d;
      s1_q   <= s1_d;
      s0_q   <= s0_d;
      pm_q   <= pm_d;
      roll_q <= roll_d;
      lerr_q <= lerr_d;
    end
  end

`ifdef BCD_TIME_ALARM_EN
  logic       alarm_q;
  logic [5:0] acnt_q;
  logic       alarm_rise;

  // Fires on a normal tick that carries seconds to 00 onto the alarm H:M.
  assign alarm_rise = !LOAD && !setting && tick && s_carry &&
                      ({h1_d, h0_d, m1_d, m0_d} == {ALARM_H1, ALARM_H0, ALARM_M1, ALARM_M0});
  assign ALARM = alarm_q;

  // Alarm level held for 60 ticks; set mode cancels it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      alarm_q <= 1'b0;
      acnt_q  <= '0;
    end else if (setting) begin
      alarm_q <= 1'b0;
      acnt_q  <= '0;
    end else if (alarm_rise) begin
      alarm_q <= 1'b1;
      acnt_q  <= '0;
    end else if (alarm_q && tick) begin
      if (acnt_q == 6'd59) begin
        alarm_q <= 1'b0;
        acnt_q  <= '0;
      end else begin
        acnt_q <= acnt_q + 6'd1;
      end
    end
  end
`else
  logic unused_alarm;
  assign unused_alarm = ^{ALARM_H1, ALARM_H0, ALARM_M1, ALARM_M0};
  assign ALARM = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_time_counter.sv
// Directed bench for bcd_time_counter: one 24h and one 12h instance, MAIN_CLK=2.
`timescale 1ns/1ps
module tb_bcd_time_counter;

`ifdef BCD_TIME_ALARM_EN
  localparam logic ALARM_ON = 1'b1;
`else
  localparam logic ALARM_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // 24h instance
  logic       set_n_a = 1'b1, load_a = 1'b0;
  logic [1:0] lh1_a = '0;
  logic [3:0] lh0_a = '0;
  logic [2:0] lm1_a = '0;
  logic [3:0] lm0_a = '0;
  logic       tick_a, pm_a, roll_a, setting_a, lerr_a, alarm_a;
  logic [1:0] h1_a;
  logic [3:0] h0_a, m0_a, s0_a;
  logic [2:0] m1_a, s1_a;
  logic [19:0] tod_a;
  assign tod_a = {h1_a, h0_a, m1_a, m0_a, s1_a, s0_a};

  // 12h instance
  logic       set_n_b = 1'b1, load_b = 1'b0;
  logic [1:0] lh1_b = '0;
  logic [3:0] lh0_b = '0;
  logic [2:0] lm1_b = '0;
  logic [3:0] lm0_b = '0;
  logic       tick_b, pm_b, roll_b, setting_b, lerr_b, alarm_b;
  logic [1:0] h1_b;
  logic [3:0] h0_b, m0_b, s0_b;
  logic [2:0] m1_b, s1_b;
  logic [19:0] tod_b;
  assign tod_b = {h1_b, h0_b, m1_b, m0_b, s1_b, s0_b};

  bcd_time_counter #(.MAIN_CLK(2), .SET_RATE(8), .MODE_12H(0)) u_dut24 (
    .CLK(clk), .RST(rst), .SET_N(set_n_a), .LOAD(load_a),
    .LOAD_H1(lh1_a), .LOAD_H0(lh0_a), .LOAD_M1(lm1_a), .LOAD_M0(lm0_a),
    .ALARM_H1(2'd0), .ALARM_H0(4'd0), .ALARM_M1(3'd0), .ALARM_M0(4'd2),
    .TICK_1HZ(tick_a), .H1(h1_a), .H0(h0_a), .M1(m1_a), .M0(m0_a), .S1(s1_a), .S0(s0_a),
    .PM(pm_a), .ROLLOVER(roll_a), .SETTING(setting_a), .LOAD_ERR(lerr_a), .ALARM(alarm_a)
  );

  bcd_time_counter #(.MAIN_CLK(2), .SET_RATE(8), .MODE_12H(1)) u_dut12 (
    .CLK(clk), .RST(rst), .SET_N(set_n_b), .LOAD(load_b),
    .LOAD_H1(lh1_b), .LOAD_H0(lh0_b), .LOAD_M1(lm1_b), .LOAD_M0(lm0_b),
    .ALARM_H1(2'd0), .ALARM_H0(4'd0), .ALARM_M1(3'd0), .ALARM_M0(4'd0),
    .TICK_1HZ(tick_b), .H1(h1_b), .H0(h0_b), .M1(m1_b), .M0(m0_b), .S1(s1_b), .S0(s0_b),
    .PM(pm_b), .ROLLOVER(roll_b), .SETTING(setting_b), .LOAD_ERR(lerr_b), .ALARM(alarm_b)
  );

  function automatic logic [19:0] hms(input int h, input int m, input int s);
    return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
  endfunction

  function automatic string fmt(input logic [19:0] t);
    return $sformatf("%0d%0d:%0d%0d:%0d%0d", t[19:18], t[17:14], t[13:11], t[10:7],
                     t[6:4], t[3:0]);
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load24(input int h, input int m1, input int m0);
    lh1_a = 2'(h / 10); lh0_a = 4'(h % 10); lm1_a = 3'(m1); lm0_a = 4'(m0);
    load_a = 1'b1;
    cyc(1);
    load_a = 1'b0;
  endtask

  task automatic load12(input int h, input int m);
    lh1_b = 2'(h / 10); lh0_b = 4'(h % 10); lm1_b = 3'(m / 10); lm0_b = 4'(m % 10);
    load_b = 1'b1;
    cyc(1);
    load_b = 1'b0;
  endtask

  task automatic test_reset;
    cyc(2);
    n_checks++;
    if (tod_a !== hms(0, 0, 0)) begin
      n_fail++; $display("FAIL reset_tod24: got %s want 00:00:00", fmt(tod_a));
    end
    n_checks++;
    if ({tick_a, pm_a, roll_a, setting_a, lerr_a, alarm_a} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags24: got %b want 000000",
               {tick_a, pm_a, roll_a, setting_a, lerr_a, alarm_a});
    end
    n_checks++;
    if (tod_b !== hms(12, 0, 0) || pm_b !== 1'b0) begin
      n_fail++; $display("FAIL reset_tod12: got %s pm=%b want 12:00:00 pm=0", fmt(tod_b), pm_b);
    end
    rst = 1'b0;
  endtask

  task automatic test_count;
    cyc(1);
    n_checks++;
    if (tick_a !== 1'b1 || s0_a !== 4'd0) begin
      n_fail++; $display("FAIL first_tick: got tick=%b s0=%0d want tick=1 s0=0", tick_a, s0_a);
    end
    cyc(1);
    n_checks++;
    if (tick_a !== 1'b0 || tod_a !== hms(0, 0, 1)) begin
      n_fail++; $display("FAIL first_count: got tick=%b %s want tick=0 00:00:01", tick_a, fmt(tod_a));
    end
    cyc(116);
    n_checks++;
    if (tod_a !== hms(0, 0, 59)) begin
      n_fail++; $display("FAIL count_59: got %s want 00:00:59", fmt(tod_a));
    end
    cyc(2);
    n_checks++;
    if (tod_a !== hms(0, 1, 0)) begin
      n_fail++; $display("FAIL sec_carry: got %s want 00:01:00", fmt(tod_a));
    end
  endtask

  task automatic test_rollover;
    load24(23, 5, 9);
    n_checks++;
    if (tod_a !== hms(23, 59, 0) || roll_a !== 1'b0) begin
      n_fail++; $display("FAIL load_2359: got %s roll=%b want 23:59:00 roll=0", fmt(tod_a), roll_a);
    end
    cyc(119);
    n_checks++;
    if (tod_a !== hms(23, 59, 59) || roll_a !== 1'b0) begin
      n_fail++; $display("FAIL pre_wrap: got %s roll=%b want 23:59:59 roll=0", fmt(tod_a), roll_a);
    end
    cyc(1);
    n_checks++;
    if (tod_a !== hms(0, 0, 0) || roll_a !== 1'b1) begin
      n_fail++; $display("FAIL day_wrap: got %s roll=%b want 00:00:00 roll=1", fmt(tod_a), roll_a);
    end
    cyc(1);
    n_checks++;
    if (roll_a !== 1'b0) begin
      n_fail++; $display("FAIL roll_pulse: got roll=%b want 0", roll_a);
    end
  endtask

  task automatic test_load_reject;
    int hv[3] = '{24, 12, 5};
    int m1v[3] = '{0, 6, 0};
    int m0v[3] = '{0, 0, 10};
    logic [19:0] e;
    e = hms(0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      load24(hv[i], m1v[i], m0v[i]);
      n_checks++;
      if (lerr_a !== 1'b1 || tod_a[19:7] !== e[19:7]) begin
        n_fail++;
        $display("FAIL reject24_%0d: got err=%b %s want err=1 00:00", i, lerr_a, fmt(tod_a));
      end
    end
    cyc(1);
    n_checks++;
    if (lerr_a !== 1'b0) begin
      n_fail++; $display("FAIL err_pulse: got err=%b want 0", lerr_a);
    end
  endtask

  task automatic test_set;
    load24(23, 5, 8);
    set_n_a = 1'b0;
    cyc(1);
    n_checks++;
    if (setting_a !== 1'b0) begin
      n_fail++; $display("FAIL set_sync1: got setting=%b want 0", setting_a);
    end
    cyc(1);
    n_checks++;
    if (setting_a !== 1'b1 || tod_a[19:7] !== hms(23, 58, 0) >> 7) begin
      n_fail++; $display("FAIL set_sync2: got setting=%b %s want 1 23:58", setting_a, fmt(tod_a));
    end
    cyc(1);
    n_checks++;
    if (tod_a !== hms(23, 59, 0) || roll_a !== 1'b0) begin
      n_fail++; $display("FAIL set_adv1: got %s roll=%b want 23:59:00 roll=0", fmt(tod_a), roll_a);
    end
    cyc(1);
    n_checks++;
    if (tod_a !== hms(0, 0, 0) || roll_a !== 1'b1) begin
      n_fail++; $display("FAIL set_wrap: got %s roll=%b want 00:00:00 roll=1", fmt(tod_a), roll_a);
    end
    cyc(1);
    n_checks++;
    if (tod_a !== hms(0, 1, 0) || roll_a !== 1'b0) begin
      n_fail++; $display("FAIL set_adv3: got %s roll=%b want 00:01:00 roll=0", fmt(tod_a), roll_a);
    end
    set_n_a = 1'b1;
    cyc(2);
    n_checks++;
    if (setting_a !== 1'b0 || tod_a !== hms(0, 3, 0)) begin
      n_fail++; $display("FAIL set_release: got setting=%b %s want 0 00:03:00", setting_a, fmt(tod_a));
    end
    cyc(1);
    n_checks++;
    if (tod_a !== hms(0, 3, 1)) begin
      n_fail++; $display("FAIL set_resume: got %s want 00:03:01", fmt(tod_a));
    end
  endtask

  task automatic test_12h;
    int hv[4] = '{11, 12, 9, 11};
    int mv[4] = '{59, 59, 59, 59};
    int eh[4] = '{12, 1, 10, 12};
    logic epm[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic erl[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [19:0] e;
    for (int i = 0; i < 4; i++) begin
      load12(hv[i], mv[i]);
      cyc(120);
      n_checks++;
      if (tod_b !== hms(eh[i], 0, 0) || pm_b !== epm[i] || roll_b !== erl[i]) begin
        n_fail++;
        $display("FAIL wrap12_%0d: got %s pm=%b roll=%b want %0d:00:00 pm=%b roll=%b",
                 i, fmt(tod_b), pm_b, roll_b, eh[i], epm[i], erl[i]);
      end
    end
    e = hms(12, 0, 0);
    load12(0, 30);
    n_checks++;
    if (lerr_b !== 1'b1 || tod_b[19:7] !== e[19:7]) begin
      n_fail++; $display("FAIL reject12_0030: got err=%b %s want err=1 12:00", lerr_b, fmt(tod_b));
    end
    load12(13, 0);
    n_checks++;
    if (lerr_b !== 1'b1 || tod_b[19:7] !== e[19:7]) begin
      n_fail++; $display("FAIL reject12_1300: got err=%b %s want err=1 12:00", lerr_b, fmt(tod_b));
    end
  endtask

  task automatic test_reset_mid_set;
    load24(5, 3, 7);
    set_n_a = 1'b0;
    cyc(3);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (tod_a !== hms(0, 0, 0) || setting_a !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: got %s setting=%b want 00:00:00 0", fmt(tod_a), setting_a);
    end
    n_checks++;
    if (tod_b !== hms(12, 0, 0) || pm_b !== 1'b0) begin
      n_fail++; $display("FAIL async_reset12: got %s pm=%b want 12:00:00 pm=0", fmt(tod_b), pm_b);
    end
    @(negedge clk);
    set_n_a = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(1);
    n_checks++;
    if (tick_a !== 1'b1 || tod_a !== hms(0, 0, 0)) begin
      n_fail++; $display("FAIL post_reset_tick: got tick=%b %s want 1 00:00:00", tick_a, fmt(tod_a));
    end
    cyc(1);
    n_checks++;
    if (tod_a !== hms(0, 0, 1)) begin
      n_fail++; $display("FAIL post_reset_count: got %s want 00:00:01", fmt(tod_a));
    end
  endtask

  task automatic test_alarm;
    cyc(236);
    n_checks++;
    if (tod_a !== hms(0, 1, 59) || alarm_a !== 1'b0) begin
      n_fail++; $display("FAIL alarm_pre: got %s alarm=%b want 00:01:59 0", fmt(tod_a), alarm_a);
    end
    cyc(2);
    n_checks++;
    if (tod_a !== hms(0, 2, 0) || alarm_a !== ALARM_ON) begin
      n_fail++; $display("FAIL alarm_rise: got %s alarm=%b want 00:02:00 %b", fmt(tod_a), alarm_a, ALARM_ON);
    end
    cyc(118);
    n_checks++;
    if (alarm_a !== ALARM_ON) begin
      n_fail++; $display("FAIL alarm_hold: got %b want %b", alarm_a, ALARM_ON);
    end
    cyc(2);
    n_checks++;
    if (tod_a !== hms(0, 3, 0) || alarm_a !== 1'b0) begin
      n_fail++; $display("FAIL alarm_drop: got %s alarm=%b want 00:03:00 0", fmt(tod_a), alarm_a);
    end
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(240);
    n_checks++;
    if (tod_a !== hms(0, 2, 0) || alarm_a !== ALARM_ON) begin
      n_fail++; $display("FAIL alarm_rise2: got %s alarm=%b want 00:02:00 %b", fmt(tod_a), alarm_a, ALARM_ON);
    end
    set_n_a = 1'b0;
    cyc(2);
    n_checks++;
    if (setting_a !== 1'b1 || alarm_a !== ALARM_ON) begin
      n_fail++; $display("FAIL alarm_set_edge: got setting=%b alarm=%b want 1 %b", setting_a, alarm_a, ALARM_ON);
    end
    cyc(1);
    n_checks++;
    if (alarm_a !== 1'b0) begin
      n_fail++; $display("FAIL alarm_cancel: got %b want 0", alarm_a);
    end
    set_n_a = 1'b1;
    cyc(3);
  endtask

  initial begin
    test_reset;
    test_count;
    test_rollover;
    test_load_reject;
    test_set;
    test_12h;
    test_reset_mid_set;
    test_alarm;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
